phase_shifter_tx: RTL and testbench
===================================

// Module: phase_shifter_tx
// PURPOSE
//  Transmit-side counterpart of the deser400 phase selector. Takes one data bit per CLK400
//  cycle, expands it to 8 samples (1/8-bit resolution) and delays the sample stream by a
//  programmable 0..15 sub-bit phases. The result is an 8-bit word per cycle for an external
//  8:1 output serializer. Phase changes are applied only while the data is quiet, so the
//  switch produces no runt pulses.
// PARAMETERS
//  QUIET_TIMEOUT  255  cycles spent waiting for a quiet window before a phase change is forced (1..255)
// PORTS
//  CLK400       in   1  400 MHz clock; sole clock domain
//  reset        in   1  synchronous, active-high reset
//  serin        in   1  data bit b[k], sampled every CLK400 edge
//  phsel        in   4  requested delay d in 1/8-bit steps (0..15); sampled on phsel_load
//  phsel_load   in   1  1-cycle request to change phase
//  phsel_busy   out  1  phase-change request in progress
//  phsel_err    out  1  1-cycle pulse: phsel_load arrived while busy and was dropped
//  serout       out  8  sample word for serializer; bit 0 transmitted first
// BEHAVIOUR
//  - Sample stream: x[8k+i] = b[k], for i = 0..7. Output stream: serout at cycle m, bit i = y[8m+i].
//  - Transfer: y[j] = x[j - 16 - d]. This is a fixed 2-cycle pipeline plus d samples;
//    d is the active phase. Samples that originate before reset release are 0.
//  - History: 3-bit register {h2,h1,h0} of past serin bits. The output word is an 8-sample
//    window into the 24-sample expansion of that history, at offset d.
//  - Reset values: serout=8'h00, phsel_busy=0, phsel_err=0, active d=0, history=0,
//    FSM=IDLE, timeout counter=0.
//  - Reset mid-operation: any pending request is discarded and d returns to 0.
//  - FSM IDLE:
//    - phsel_load=1 latches phsel into pend; next state WAIT; phsel_busy=1 from the next cycle.
//  - FSM WAIT:
//    - quiet = (h0==h1 && h1==h2), i.e. the whole 24-sample window is uniform.
//    - If quiet, or the counter reaches QUIET_TIMEOUT, go to APPLY; otherwise the counter increments.
//  - FSM APPLY (1 cycle):
//    - d <= pend and the counter clears.
//    - The serout word registered on the next edge uses the new d.
//    - Return to IDLE; phsel_busy deasserts one cycle after APPLY.
//  - Quiet switch: the old-d and new-d words are identical, so there is no glitch.
//    A forced (timeout) switch may glitch; this is accepted.
//  - phsel_load while phsel_busy=1: the request is ignored and phsel_err pulses for 1 cycle
//    on the following edge.
//  - phsel_load with phsel equal to the current d: the FSM still runs, and the switch is a no-op.
//  - Timeout count is saturating; QUIET_TIMEOUT=1 applies after at most 1 WAIT cycle.
//  - d=0 with serin constant at 1 gives serout=8'hFF from 2 cycles after serin rises.
// CONFIGURATION
//  PHASE_TX_PRBS_EN defined:
//    - Adds input port prbs_en (1 bit).
//    - When prbs_en=1, a PRBS7 generator (x^7+x^6+1, seed 7'h7F on reset, 1 bit/cycle)
//      replaces serin at the history input. The serin path is unchanged when prbs_en=0.
//  PHASE_TX_PRBS_EN undefined:
//    - prbs_en port is absent and there is no PRBS logic; serin feeds the history directly.
// TESTING
//  1. Reset held 3 cycles with serin=1: serout=8'h00, busy=0 throughout; d=0 afterwards.
//  2. d=0; serin 0->1 at cycle 10: serout=8'h00 until cycle 11, then 8'hFF from cycle 12.
//  3. d=3 via a quiet load; single 1-bit pulse on serin: serout words 8'hF8 then 8'h07
//     (5 ones, then 3 ones).
//  4. Data constant 0; phsel=9, phsel_load pulse: busy=1 for exactly 3 cycles; no serout bit ever set.
//  5. Alternating serin 1010...; load phsel=5 with QUIET_TIMEOUT=4: forced apply after
//     4 WAIT cycles; busy=0 by load+7.
//  6. Second phsel_load 1 cycle after the first: phsel_err pulses once and the first
//     request's phase wins.
//     With PHASE_TX_PRBS_EN and prbs_en=1, d=0: the bit stream repeats every 127 cycles.

Source files
------------

// File: rtl/phase_shifter_tx_if.sv
// Phase shifter transmit bus: serial data in, phase control and 8-sample word out.
// prbs_en exists only when PHASE_TX_PRBS_EN is defined.
interface phase_shifter_tx_if;
   logic       serin;
   logic [3:0] phsel;
   logic       phsel_load;
   logic       phsel_busy;
   logic       phsel_err;
   logic [7:0] serout;
`ifdef PHASE_TX_PRBS_EN
   logic       prbs_en;

   modport master (output serin, phsel, phsel_load, prbs_en,
                   input  phsel_busy, phsel_err, serout);
   modport slave  (input  serin, phsel, phsel_load, prbs_en,
                   output phsel_busy, phsel_err, serout);
`else
   modport master (output serin, phsel, phsel_load,
                   input  phsel_busy, phsel_err, serout);
   modport slave  (input  serin, phsel, phsel_load,
                   output phsel_busy, phsel_err, serout);
`endif
endinterface

// File: rtl/phase_shifter_tx.sv
// Expands serin to 8 samples/bit and delays it by 0..15 sub-bit phases; PHASE_TX_PRBS_EN adds a PRBS7 source.
// Latency 2 cycles + d samples; no backpressure, loads arriving while busy are dropped and flagged on phsel_err.
module phase_shifter_tx #(
   parameter int QUIET_TIMEOUT = 255
) (
   input  logic              CLK400,
   input  logic              reset,
   phase_shifter_tx_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] APPLY = 2'd2;

   logic [1:0]  state;
   logic [2:0]  hist;
   logic [3:0]  d;
   logic [3:0]  pend;
   logic [7:0]  cnt;
   logic [8:0]  cnt_inc;
   logic [23:0] expand;
   logic [4:0]  base;
   logic [7:0]  word;
   logic        busy;
   logic        err;
   logic        quiet;
   logic        accept;
   logic        bit_in;

`ifdef PHASE_TX_PRBS_EN
   logic [6:0] prbs;

   always_ff @(posedge CLK400) begin
      if (reset) begin
         prbs <= 7'h7F;
      end else begin
         prbs <= {prbs[5:0], prbs[6] ^ prbs[5]};
      end
   end

   assign bit_in = bus.prbs_en ? prbs[6] : bus.serin;
`else
   assign bit_in = bus.serin;
`endif

   // hist[0] is the newest bit; the oldest bit occupies the low 8 sample positions.
   assign expand  = {{8{hist[0]}}, {8{hist[1]}}, {8{hist[2]}}};
   assign base    = 5'd16 - {1'b0, d};
   assign quiet   = (hist[0] == hist[1]) && (hist[1] == hist[2]);
   assign accept  = bus.phsel_load && !busy;
   assign cnt_inc = {1'b0, cnt} + 9'd1;

   always_ff @(posedge CLK400) begin
      if (reset) begin
         hist  <= '0;
         word  <= '0;
         busy  <= 1'b0;
         err   <= 1'b0;
         d     <= '0;
         pend  <= '0;
         cnt   <= '0;
         state <= IDLE;
      end else begin
         hist <= {hist[1:0], bit_in};
         word <= expand[base +: 8];
         err  <= bus.phsel_load && busy;
         case (state)
            IDLE: begin
               // busy lingers one cycle past APPLY, so a load right then is still refused
               busy <= accept;
               if (accept) begin
                  pend  <= bus.phsel;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (quiet || (cnt_inc >= 9'(QUIET_TIMEOUT))) begin
                  state <= APPLY;
               end
               if (cnt != 8'hFF) begin
                  cnt <= cnt_inc[7:0];
               end
            end
            APPLY: begin
               d     <= pend;
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.serout     = word;
   assign bus.phsel_busy = busy;
   assign bus.phsel_err  = err;
endmodule

// File: tb/tb_phase_shifter_tx.sv
// Bench for phase_shifter_tx: directed steps then random traffic against a sample-stream reference model.
module tb_phase_shifter_tx;
   localparam int TO    = 4;
   localparam int NHIST = 4096;

   logic clk = 1'b0;
   logic reset;

   phase_shifter_tx_if bus ();

   phase_shifter_tx #(.QUIET_TIMEOUT(TO)) dut (
      .CLK400 (clk),
      .reset  (reset),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int fails   = 0;
   int e       = 0;

   // reference model: bit sampled at each edge, and request bookkeeping
   bit         b_hist [NHIST];
   logic [3:0] m_d        = 4'd0;
   logic [3:0] m_pend     = 4'd0;
   bit         m_busy     = 1'b0;
   bit         m_wait     = 1'b0;
   int         m_wcnt     = 0;
   int         m_apply_at = -1;
   int         m_off_at   = -1;
   logic [7:0] exp_so;
   bit         exp_busy;
   bit         exp_err;

   function automatic bit bget(input int k);
      if (k < 1 || k >= NHIST) return 1'b0;
      return b_hist[k];
   endfunction

   // y[j] = x[j-16-d]; the word after edge n holds samples of bits up to b[n-1]
   function automatic logic [7:0] model_word(input int n, input logic [3:0] dd);
      logic [7:0] w;
      int idx;
      w = 8'h00;
      for (int i = 0; i < 8; i++) begin
         idx  = 8 * (n - 1) + i - int'(dd);
         w[i] = bget(idx >>> 3);
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vectors++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, expv);
      end
   endtask

   task automatic tick(input bit s, input bit ld, input logic [3:0] ps, input bit r);
      bit bp;
      bit q;
      @(negedge clk);
      bus.serin      = s;
      bus.phsel_load = ld;
      bus.phsel      = ps;
      reset          = r;
      @(posedge clk);
      e++;
      if (r) begin
         if (e < NHIST) b_hist[e] = 1'b0;
         m_d = 4'd0; m_busy = 1'b0; m_wait = 1'b0; m_wcnt = 0;
         m_apply_at = -1; m_off_at = -1;
         exp_so = 8'h00; exp_busy = 1'b0; exp_err = 1'b0;
      end else begin
         if (m_apply_at == e) m_d = m_pend;
         exp_so  = model_word(e, m_d);
         bp      = m_busy;
         exp_err = ld && bp;
         if (m_off_at == e) m_busy = 1'b0;
         if (m_wait) begin
            m_wcnt++;
            q = (bget(e - 1) == bget(e - 2)) && (bget(e - 2) == bget(e - 3));
            if (q || m_wcnt >= TO) begin
               m_wait     = 1'b0;
               m_apply_at = e + 2;
               m_off_at   = e + 2;
            end
         end
         if (ld && !bp) begin
            m_wait = 1'b1; m_wcnt = 0; m_pend = ps; m_busy = 1'b1;
         end
         if (e < NHIST) b_hist[e] = s;
         exp_busy = m_busy;
      end
      #1;
      chk("serout", bus.serout, exp_so);
      chk("busy", {7'd0, bus.phsel_busy}, {7'd0, exp_busy});
      chk("err", {7'd0, bus.phsel_err}, {7'd0, exp_err});
   endtask

   initial begin
      bit cur;
      int bc;
      bus.serin      = 1'b0;
      bus.phsel      = 4'd0;
      bus.phsel_load = 1'b0;
      reset          = 1'b1;
`ifdef PHASE_TX_PRBS_EN
      bus.prbs_en    = 1'b0;
`endif

      // reset held 3 cycles with serin high
      repeat (3) tick(1'b1, 1'b0, 4'd0, 1'b1);

      // d=0, serin rises at edge 10
      repeat (6) tick(1'b0, 1'b0, 4'd0, 1'b0);
      tick(1'b1, 1'b0, 4'd0, 1'b0);
      chk("t2_before", bus.serout, 8'h00);
      tick(1'b1, 1'b0, 4'd0, 1'b0);
      chk("t2_after", bus.serout, 8'hFF);
      tick(1'b1, 1'b0, 4'd0, 1'b0);

      // quiet load of d=3, then a single-bit pulse
      repeat (4) tick(1'b0, 1'b0, 4'd0, 1'b0);
      tick(1'b0, 1'b1, 4'd3, 1'b0);
      repeat (4) tick(1'b0, 1'b0, 4'd0, 1'b0);
      tick(1'b1, 1'b0, 4'd0, 1'b0);
      tick(1'b0, 1'b0, 4'd0, 1'b0);
      chk("t3_first", bus.serout, 8'hF8);
      tick(1'b0, 1'b0, 4'd0, 1'b0);
      chk("t3_second", bus.serout, 8'h07);
      repeat (2) tick(1'b0, 1'b0, 4'd0, 1'b0);

      // constant-zero data, load d=9: busy exactly 3 cycles
      tick(1'b0, 1'b1, 4'd9, 1'b0);
      bc = int'(bus.phsel_busy);
      repeat (5) begin
         tick(1'b0, 1'b0, 4'd0, 1'b0);
         bc += int'(bus.phsel_busy);
      end
      chk("t4_busy_cycles", 8'(bc), 8'd3);

      // alternating data never goes quiet: forced apply after TO wait cycles
      cur = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cur = ~cur;
         tick(cur, 1'b0, 4'd0, 1'b0);
      end
      cur = ~cur;
      tick(cur, 1'b1, 4'd5, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         cur = ~cur;
         tick(cur, 1'b0, 4'd0, 1'b0);
         if (k == 5) chk("t5_busy_l5", {7'd0, bus.phsel_busy}, 8'd1);
         if (k == 6) chk("t5_busy_l6", {7'd0, bus.phsel_busy}, 8'd0);
      end

      // back-to-back loads: second dropped with an error pulse, first phase wins
      repeat (4) tick(1'b0, 1'b0, 4'd0, 1'b0);
      tick(1'b0, 1'b1, 4'd2, 1'b0);
      tick(1'b0, 1'b1, 4'd7, 1'b0);
      chk("t6_err_pulse", {7'd0, bus.phsel_err}, 8'd1);
      tick(1'b0, 1'b0, 4'd0, 1'b0);
      chk("t6_err_clear", {7'd0, bus.phsel_err}, 8'd0);
      repeat (4) tick(1'b0, 1'b0, 4'd0, 1'b0);
      tick(1'b1, 1'b0, 4'd0, 1'b0);
      tick(1'b0, 1'b0, 4'd0, 1'b0);
      chk("t6_first", bus.serout, 8'hFC);
      tick(1'b0, 1'b0, 4'd0, 1'b0);
      chk("t6_second", bus.serout, 8'h03);

      // reload of the current phase is a harmless no-op
      tick(1'b0, 1'b1, 4'd2, 1'b0);
      repeat (5) tick(1'b1, 1'b0, 4'd0, 1'b0);

      // random traffic: run-length data, sporadic loads and resets
      cur = 1'b0;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(3) == 0) cur = ~cur;
         tick(cur, $urandom_range(15) == 0, 4'($urandom_range(15)), $urandom_range(499) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
